// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer. Holds the rPLL in reset, waits for LOCK with a
// bounded number of timed-out attempts, qualifies lock stability, then releases the
// downstream domain reset. Runs entirely in the reference-clock domain.
module pll_lock_sequencer #(
    parameter int unsigned RST_HOLD_CYC     = 600,
    parameter int unsigned LOCK_TIMEOUT_CYC = 60000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              restart,
    output logic              pll_reset,
    output logic              locked,
    output logic              dom_rst_n,
    output logic              fail,
    output logic [RetryW-1:0] retry_cnt
);

    localparam int unsigned MaxAb  = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ?
                                     RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned MaxCyc = (MaxAb > LOCK_STABLE_CYC) ? MaxAb : LOCK_STABLE_CYC;
    // Counter only ever reaches MaxCyc-1; keep at least one bit for degenerate sizes.
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    typedef enum logic [2:0] {
        StHold,
        StWait,
        StStable,
        StRun,
        StFail
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              lock_meta_q, lock_s_q;
    logic              pll_reset_q, pll_reset_d;
    logic              locked_q, locked_d;
    logic              dom_rst_n_q, dom_rst_n_d;
    logic              fail_q, fail_d;

    // Two-flop synchroniser for the asynchronous PLL LOCK output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state, shared cycle counter and retry bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        retry_d = retry_q;
        if (restart) begin
            state_d = StHold;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_q == CntW'(RST_HOLD_CYC - 1)) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
                StWait: begin
                    // Lock wins over a coincident timeout.
                    if (lock_s_q) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYC - 1)) begin
                        cnt_d = '0;
                        if (retry_q == RetryW'(MAX_RETRY)) begin
                            state_d = StFail;
                        end else begin
                            state_d = StHold;
                            retry_d = retry_q + RetryW'(1);
                        end
                    end
                end
                StStable: begin
                    if (!lock_s_q) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end else if (cnt_q == CntW'(LOCK_STABLE_CYC - 1)) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!lock_s_q) begin
                        state_d = StHold;
                        retry_d = '0;
                    end
                end
                StFail: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StHold;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they move on the same edge as the state.
    always_comb begin
        pll_reset_d = (state_d == StHold) || (state_d == StFail);
        locked_d    = (state_d == StRun);
        dom_rst_n_d = (state_d == StRun);
        fail_d      = (state_d == StFail);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            dom_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            dom_rst_n_q <= dom_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign locked    = locked_q;
    assign dom_rst_n = dom_rst_n_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output vectors are queued against
// the cycle on which they must appear and compared on the falling clock edge.
module tb_pll_lock_sequencer;

    localparam int unsigned RstHold = 4;
    localparam int unsigned Timeout = 16;
    localparam int unsigned Stable  = 8;
    localparam int unsigned MaxRtry = 2;

    // Observed vector layout: {pll_reset, locked, dom_rst_n, fail, retry_cnt[1:0]}
    localparam logic [5:0] VHold = 6'b100000;
    localparam logic [5:0] VWait = 6'b000000;
    localparam logic [5:0] VRun  = 6'b011000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset, locked, dom_rst_n, fail;
    logic [1:0] retry_cnt;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  exp;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYC     (RstHold),
        .LOCK_TIMEOUT_CYC (Timeout),
        .LOCK_STABLE_CYC  (Stable),
        .MAX_RETRY        (MaxRtry)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .restart   (restart),
        .pll_reset (pll_reset),
        .locked    (locked),
        .dom_rst_n (dom_rst_n),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] obs();
        return {pll_reset, locked, dom_rst_n, fail, retry_cnt};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Queue an expectation, kept sorted by target cycle.
    task automatic push_exp(input int unsigned c, input logic [5:0] e, input string tag);
        exp_t it;
        int   idx;
        it.cyc = c;
        it.exp = e;
        it.tag = tag;
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, it);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare queued expectations that fall due on this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t it;
            it = sb_q.pop_front();
            if (it.cyc == cyc) check_eq(it.tag, 32'(obs()), 32'(it.exp));
            else check_eq({"late_", it.tag}, cyc, it.cyc);
        end
    end

    initial begin
        int unsigned b, t, r, g, d, p;

        // Reset values
        #1 rst_n = 1'b0;
        step(2);
        check_eq("reset_vals", 32'(obs()), 32'(VHold));

        // Normal lock
        rst_n = 1'b1;
        b = cyc;
        for (int k = 1; k <= 3; k++) push_exp(b + k, VHold, "norm_hold");
        push_exp(b + 4, VWait, "norm_wait");
        step(9);
        pll_lock = 1'b1;
        push_exp(b + 19, VWait, "norm_prelock");
        push_exp(b + 20, VRun, "norm_locked");
        step(12);

        // Lock loss in RUN, then recovery
        t = cyc;
        pll_lock = 1'b0;
        push_exp(t + 2, VRun, "loss_still_run");
        for (int k = 3; k <= 6; k++) push_exp(t + k, VHold, "loss_hold");
        push_exp(t + 7, VWait, "loss_wait");
        step(7);
        pll_lock = 1'b1;
        push_exp(t + 17, VWait, "recov_prelock");
        push_exp(t + 18, VRun, "recov_locked");
        step(20);

        // Restart from RUN, then glitchy lock in WAIT
        r = cyc;
        restart = 1'b1;
        pll_lock = 1'b0;
        for (int k = 1; k <= 4; k++) push_exp(r + k, VHold, "rst_run_hold");
        push_exp(r + 5, VWait, "rst_run_wait");
        step(1);
        restart = 1'b0;
        step(5);
        g = cyc;
        pll_lock = 1'b1;
        for (int k = 1; k <= 20; k++) push_exp(g + k, VWait, "glitch_nolock");
        push_exp(g + 21, VRun, "glitch_final_lock");
        step(5);
        pll_lock = 1'b0;
        step(5);
        pll_lock = 1'b1;
        step(12);

        // Async reset while in STABLE
        d = cyc;
        restart = 1'b1;
        pll_lock = 1'b0;
        step(1);
        restart = 1'b0;
        step(5);
        pll_lock = 1'b1;
        step(6);
        check_eq("pre_async_stable", 32'(obs()), 32'(VWait));
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'(obs()), 32'(VHold));
        pll_lock = 1'b0;
        step(2);

        // No lock ever: three attempts then sticky FAIL
        rst_n = 1'b1;
        b = cyc;
        for (int k = 1; k <= 160; k++) begin
            logic [5:0] e;
            if (k >= 60) e = 6'b100110;
            else e = {((k % 20) < 4), 3'b000, 2'(k / 20)};
            push_exp(b + k, e, "nolock");
        end
        step(161);

        // Restart in FAIL, restart coincident with a timeout, then a plain timeout
        p = cyc;
        restart = 1'b1;
        for (int k = 1; k <= 4; k++) push_exp(p + k, VHold, "fail_rst_hold");
        for (int k = 5; k <= 20; k++) push_exp(p + k, VWait, "fail_rst_wait");
        for (int k = 21; k <= 24; k++) push_exp(p + k, VHold, "to_rst_hold");
        for (int k = 25; k <= 40; k++) push_exp(p + k, VWait, "to_rst_wait");
        push_exp(p + 41, 6'b100001, "timeout_retry1");
        step(1);
        restart = 1'b0;
        step(19);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        step(22);

        check_eq("drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
